// File: rtl/mux_scan_scheduler.sv
// Round-robin scan sequencer for an 8:1 switch-scan datapath.
// Single clock, tick-enable divider, free-run and single-step modes.
module mux_scan_scheduler #(
   parameter int RATE  = 50000000,
   parameter int CNT_W = 26
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic       iRun,
   input  logic       iStep,
   input  logic [7:0] iMask,
   input  logic [7:0] iSw,
   output logic [2:0] oSelect,
   output logic       oData,
   output logic       oValid,
   output logic       oFrameDone,
   output logic       oIdle
);

   typedef enum logic {IDLE, SCAN} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(RATE - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             step_q;
   logic [2:0]       sel_q, sel_d;
   logic             data_q, data_d;
   logic             valid_q, valid_d;
   logic             frame_q, frame_d;
   logic             idle_q;

   logic             mask_any;
   logic             step_edge;
   logic             tick;
   logic             advance;
   logic [2:0]       nxt;
   logic [2:0]       cand;
   logic             found;

   assign mask_any  = |iMask;
   assign step_edge = iStep & ~step_q;
   assign tick      = (state_q == SCAN) && (cnt_q == LAST);

   // Next enabled channel above the current one, wrapping; itself if alone.
   always_comb begin
      nxt   = sel_q;
      found = 1'b0;
      cand  = sel_q;
      for (int k = 1; k <= 8; k++) begin
         cand = sel_q + 3'(k);
         if (!found && iMask[cand]) begin
            nxt   = cand;
            found = 1'b1;
         end
      end
   end

   // FSM next state, divider and advance decision.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      advance = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (iRun && mask_any) begin
               state_d = SCAN;
               cnt_d   = '0;
            end else if (step_edge && !iRun && mask_any) begin
               advance = 1'b1;
            end
         end
         SCAN: begin
            if (!iRun || !mask_any) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (tick) begin
               advance = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   // Output next values: capture on advance, hold otherwise.
   always_comb begin
      sel_d   = sel_q;
      data_d  = data_q;
      valid_d = 1'b0;
      frame_d = 1'b0;
      if (advance) begin
         sel_d   = nxt;
         data_d  = iSw[nxt];
         valid_d = 1'b1;
         frame_d = (nxt <= sel_q);
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         step_q  <= 1'b0;
         sel_q   <= 3'd0;
         data_q  <= 1'b0;
         valid_q <= 1'b0;
         frame_q <= 1'b0;
         idle_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         step_q  <= iStep;
         sel_q   <= sel_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         frame_q <= frame_d;
         idle_q  <= (state_d == IDLE);
      end
   end

   assign oSelect    = sel_q;
   assign oData      = data_q;
   assign oValid     = valid_q;
   assign oFrameDone = frame_q;
   assign oIdle      = idle_q;

endmodule

// File: tb/tb_mux_scan_scheduler.sv
// Bench for mux_scan_scheduler: vector table, directed sequences,
// and random stimulus against a channel-list reference model.
module tb_mux_scan_scheduler;

   localparam int RATE  = 4;
   localparam int CNT_W = 4;

   logic       iClk = 1'b0;
   logic       iRst = 1'b1;
   logic       iRun = 1'b0;
   logic       iStep = 1'b0;
   logic [7:0] iMask = 8'h00;
   logic [7:0] iSw = 8'h00;
   logic [2:0] oSelect;
   logic       oData;
   logic       oValid;
   logic       oFrameDone;
   logic       oIdle;

   mux_scan_scheduler #(.RATE(RATE), .CNT_W(CNT_W)) dut (
      .iClk(iClk), .iRst(iRst), .iRun(iRun), .iStep(iStep),
      .iMask(iMask), .iSw(iSw), .oSelect(oSelect), .oData(oData),
      .oValid(oValid), .oFrameDone(oFrameDone), .oIdle(oIdle)
   );

   always #5 iClk = ~iClk;

   int checks = 0;
   int failures = 0;
   int ncyc = 0;

   bit       m_scan, m_prev, m_data, m_valid, m_frame, m_idle;
   int       m_age;
   int       m_sel;

   int vsel[$];
   int vdat[$];
   int vfrm[$];
   int vcyc[$];

   typedef struct {
      bit         run;
      bit         stp;
      logic [2:0] sel;
      bit         data;
      bit         valid;
      bit         frame;
      bit         idle;
   } vec_t;

   vec_t vt[12];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int mnext(int cur, logic [7:0] m);
      int q[$];
      for (int n = 0; n < 8; n++)
         if (m[n]) q.push_back(n);
      foreach (q[i])
         if (q[i] > cur) return q[i];
      return q[0];
   endfunction

   task automatic model(input bit rst, input bit run, input bit stp,
                        input logic [7:0] mask, input logic [7:0] sw);
      bit adv;
      bit edg;
      int n;
      if (rst) begin
         m_scan = 0; m_age = 0; m_prev = 0; m_sel = 0;
         m_data = 0; m_valid = 0; m_frame = 0; m_idle = 1;
         return;
      end
      adv = 0;
      edg = stp && !m_prev;
      m_prev = stp;
      if (!m_scan) begin
         if (run && mask != 0) begin
            m_scan = 1;
            m_age = 0;
         end else if (edg && !run && mask != 0) begin
            adv = 1;
         end
      end else if (!run || mask == 0) begin
         m_scan = 0;
      end else begin
         if (m_age % RATE == RATE - 1) adv = 1;
         m_age++;
      end
      m_valid = adv;
      m_frame = 0;
      if (adv) begin
         n = mnext(m_sel, mask);
         m_frame = (n <= m_sel);
         m_sel = n;
         m_data = sw[n];
      end
      m_idle = !m_scan;
   endtask

   task automatic cyc(input bit rst, input bit run, input bit stp,
                      input logic [7:0] mask, input logic [7:0] sw);
      iRst = rst; iRun = run; iStep = stp; iMask = mask; iSw = sw;
      @(posedge iClk);
      model(rst, run, stp, mask, sw);
      @(negedge iClk);
      ncyc++;
      chk("model", {oSelect, oData, oValid, oFrameDone, oIdle},
          {3'(m_sel), m_data, m_valid, m_frame, m_idle});
      if (oValid === 1'b1) begin
         vsel.push_back(int'(oSelect));
         vdat.push_back(int'(oData));
         vfrm.push_back(int'(oFrameDone));
         vcyc.push_back(ncyc);
      end
   endtask

   task automatic clrq();
      vsel.delete(); vdat.delete(); vfrm.delete(); vcyc.delete();
   endtask

   initial begin
      int c0;
      int es[8];
      int ed[8];
      int ef[5];
      int xs[5];
      logic [7:0] sw;

      sw = 8'b1010_0101;

      vt[0]  = '{0, 1, 3'd1, 0, 1, 0, 1};
      vt[1]  = '{0, 0, 3'd1, 0, 0, 0, 1};
      vt[2]  = '{0, 1, 3'd2, 1, 1, 0, 1};
      vt[3]  = '{0, 0, 3'd2, 1, 0, 0, 1};
      vt[4]  = '{0, 1, 3'd3, 0, 1, 0, 1};
      vt[5]  = '{0, 1, 3'd3, 0, 0, 0, 1};
      vt[6]  = '{0, 1, 3'd3, 0, 0, 0, 1};
      vt[7]  = '{0, 1, 3'd3, 0, 0, 0, 1};
      vt[8]  = '{0, 0, 3'd3, 0, 0, 0, 1};
      vt[9]  = '{1, 1, 3'd3, 0, 0, 0, 0};
      vt[10] = '{1, 0, 3'd3, 0, 0, 0, 0};
      vt[11] = '{0, 0, 3'd3, 0, 0, 0, 1};

      @(negedge iClk);

      // Reset mid-scan, then measure first-step latency.
      cyc(1, 0, 0, 8'hFF, sw);
      for (int i = 0; i < 6; i++) cyc(0, 1, 0, 8'hFF, sw);
      cyc(1, 1, 0, 8'hFF, sw);
      cyc(1, 1, 0, 8'hFF, sw);
      chk("rst_out", {oSelect, oData, oValid, oFrameDone, oIdle},
          {3'd0, 1'b0, 1'b0, 1'b0, 1'b1});
      clrq();
      c0 = ncyc + 1;
      for (int i = 0; i < 8 * RATE + 1; i++) cyc(0, 1, 0, 8'hFF, sw);
      chk("first_valid_cyc", vcyc.size() > 0 ? vcyc[0] : -1, c0 + RATE);

      // Full sweep sequence.
      es = '{1, 2, 3, 4, 5, 6, 7, 0};
      ed = '{0, 1, 0, 0, 1, 0, 1, 1};
      chk("sweep_count", vsel.size(), 8);
      if (vsel.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            chk("sweep_sel", vsel[i], es[i]);
            chk("sweep_data", vdat[i], ed[i]);
            chk("sweep_frame", vfrm[i], (i == 7) ? 1 : 0);
            if (i > 0) chk("sweep_gap", vcyc[i] - vcyc[i-1], RATE);
         end
      end

      // Sparse mask.
      clrq();
      for (int i = 0; i < 5 * RATE; i++) cyc(0, 1, 0, 8'b1000_0100, sw);
      xs = '{2, 7, 2, 7, 2};
      ef = '{0, 0, 1, 0, 1};
      chk("sparse_count", vsel.size(), 5);
      if (vsel.size() == 5) begin
         for (int i = 0; i < 5; i++) begin
            chk("sparse_sel", vsel[i], xs[i]);
            chk("sparse_frame", vfrm[i], ef[i]);
         end
      end

      // Single enabled channel.
      clrq();
      for (int i = 0; i < 3 * RATE; i++) cyc(0, 1, 0, 8'h10, sw);
      chk("single_count", vsel.size(), 3);
      if (vsel.size() == 3) begin
         for (int i = 0; i < 3; i++) chk("single_sel", vsel[i], 4);
         chk("single_frame1", vfrm[1], 1);
         chk("single_frame2", vfrm[2], 1);
      end

      // Single-step vector table.
      cyc(1, 0, 0, 8'hFF, sw);
      for (int i = 0; i < 12; i++) begin
         cyc(0, vt[i].run, vt[i].stp, 8'hFF, sw);
         chk($sformatf("vec%0d", i),
             {oSelect, oData, oValid, oFrameDone, oIdle},
             {vt[i].sel, vt[i].data, vt[i].valid, vt[i].frame, vt[i].idle});
      end

      // Held step gives one advance.
      clrq();
      for (int i = 0; i < 10; i++) cyc(0, 0, 1, 8'hFF, sw);
      cyc(0, 0, 0, 8'hFF, sw);
      chk("held_count", vsel.size(), 1);
      chk("held_sel", oSelect, 4);

      // Step while running is discarded.
      clrq();
      cyc(0, 1, 0, 8'hFF, sw);
      cyc(0, 1, 1, 8'hFF, sw);
      cyc(0, 1, 0, 8'hFF, sw);
      cyc(0, 0, 0, 8'hFF, sw);
      chk("run_step_count", vsel.size(), 0);

      // Mask to zero mid-scan.
      cyc(1, 0, 0, 8'hFF, sw);
      for (int i = 0; i < RATE + 2; i++) cyc(0, 1, 0, 8'hFF, sw);
      clrq();
      cyc(0, 1, 0, 8'h00, sw);
      chk("mask0_idle", oIdle, 1);
      chk("mask0_sel", oSelect, 1);
      chk("mask0_valid", vsel.size(), 0);

      // Drop run at count 2, then restart.
      cyc(0, 1, 0, 8'hFF, sw);
      cyc(0, 1, 0, 8'hFF, sw);
      cyc(0, 1, 0, 8'hFF, sw);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'hFF, sw);
      clrq();
      c0 = ncyc + 1;
      for (int i = 0; i < RATE + 1; i++) cyc(0, 1, 0, 8'hFF, sw);
      chk("rerun_count", vsel.size(), 1);
      chk("rerun_cyc", vcyc.size() > 0 ? vcyc[0] : -1, c0 + RATE);

      // Clear selected channel mid-count.
      clrq();
      cyc(0, 1, 0, 8'hFF, sw);
      cyc(0, 1, 0, 8'hF3, sw);
      chk("unmask_hold", oSelect, 2);
      cyc(0, 1, 0, 8'hF3, sw);
      cyc(0, 1, 0, 8'hF3, sw);
      chk("unmask_count", vsel.size(), 1);
      chk("unmask_sel", oSelect, 4);

      // Random stimulus against the model.
      for (int i = 0; i < 3000; i++) begin
         bit r;
         bit run;
         logic [7:0] m;
         r   = ($urandom_range(0, 99) == 0);
         run = ((i / 64) % 3 != 0) ? ($urandom_range(0, 15) != 0)
                                   : ($urandom_range(0, 7) == 0);
         m   = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
         if ($urandom_range(0, 3) != 0 && i > 0) m = iMask;
         cyc(r, run, 1'($urandom_range(0, 1)), m, 8'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
